// File: rtl/hex_ctrl_pkg.sv
// Shared types and constants for the hex digit entry controller.
package hex_ctrl_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam logic [6:0]  BLANK      = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_SCROLL
  } state_e;

  // Identity of the most recently granted requester, used for round-robin.
  typedef enum logic {
    WHO_A,
    WHO_B
  } who_e;

  // Number of set valid bits; at most NUM_DIGITS, so it fits in 3 bits.
  function automatic logic [2:0] count_valid(input logic [NUM_DIGITS-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      n = n + 3'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/seg7.sv
// Hex digit to active-low seven-segment decoder, bit order {g,f,e,d,c,b,a}.
module seg7 (
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  // Pure lookup of the segment pattern for one nibble.
  always_comb begin
    seg_o = 7'b1111111;
    case (digit_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/hex_entry_ctrl.sv
// Six-digit hex entry controller: two round-robin requesters push digits
// into a shift register, which can be rotated for display or cleared.
module hex_entry_ctrl
  import hex_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_a,
  input  logic [3:0] digit_a,
  input  logic       req_b,
  input  logic [3:0] digit_b,
  output logic       gnt_a,
  output logic       gnt_b,
  input  logic       scroll_en,
  input  logic       clear,
  output logic [2:0] count,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5
);

  localparam int unsigned TW       = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

  state_e                          state_q, state_d;
  who_e                            last_q, last_d;
  logic [TW-1:0]                   tick_q, tick_d;
  logic [NUM_DIGITS-1:0][3:0]      val_q, val_d;
  logic [NUM_DIGITS-1:0]           vld_q, vld_d;
  logic                            gnt_a_q, gnt_a_d;
  logic                            gnt_b_q, gnt_b_d;
  logic                            pick_a;

  logic [NUM_DIGITS-1:0][6:0]      seg_w;
  logic [NUM_DIGITS-1:0][6:0]      hex_w;

  // State, datapath and grant registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= WHO_B;
      tick_q  <= '0;
      val_q   <= '0;
      vld_q   <= '0;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      tick_q  <= tick_d;
      val_q   <= val_d;
      vld_q   <= vld_d;
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
    end
  end

  // Next-state, arbitration and digit shift/rotate logic.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    tick_d  = tick_q;
    val_d   = val_q;
    vld_d   = vld_q;
    gnt_a_d = 1'b0;
    gnt_b_d = 1'b0;
    pick_a  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          vld_d = '0;
        end else if (scroll_en) begin
          state_d = ST_SCROLL;
          tick_d  = '0;
        end else if (req_a || req_b) begin
          // A wins when alone, or on a tie when B was granted last.
          pick_a  = req_a && (!req_b || (last_q == WHO_B));
          state_d = ST_GRANT;
          gnt_a_d = pick_a;
          gnt_b_d = !pick_a;
          last_d  = pick_a ? WHO_A : WHO_B;
          val_d   = {val_q[NUM_DIGITS-2:0], (pick_a ? digit_a : digit_b)};
          vld_d   = {vld_q[NUM_DIGITS-2:0], 1'b1};
        end
      end

      ST_GRANT: begin
        state_d = ST_IDLE;
      end

      ST_SCROLL: begin
        if (clear) begin
          vld_d = '0;
        end
        if (!scroll_en) begin
          state_d = ST_IDLE;
          tick_d  = '0;
        end else if (tick_q == TICK_MAX) begin
          tick_d = '0;
          // A simultaneous clear takes precedence over the rotation.
          if (!clear) begin
            val_d = {val_q[NUM_DIGITS-2:0], val_q[NUM_DIGITS-1]};
            vld_d = {vld_q[NUM_DIGITS-2:0], vld_q[NUM_DIGITS-1]};
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // One decoder per position, blanked when the position is not valid.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    seg7 u_seg7 (
      .digit_i (val_q[g]),
      .seg_o   (seg_w[g])
    );
    assign hex_w[g] = vld_q[g] ? seg_w[g] : BLANK;
  end

  assign gnt_a = gnt_a_q;
  assign gnt_b = gnt_b_q;
  assign count = count_valid(vld_q);
  assign hex0  = hex_w[0];
  assign hex1  = hex_w[1];
  assign hex2  = hex_w[2];
  assign hex3  = hex_w[3];
  assign hex4  = hex_w[4];
  assign hex5  = hex_w[5];

endmodule

// File: tb/tb_hex_entry_ctrl.sv
module tb_hex_entry_ctrl;

  localparam int TICK_DIV = 4;
  localparam int M_IDLE = 0, M_GRANTED = 1, M_SCROLL = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [3:0] digit_a = 4'h0, digit_b = 4'h0;
  logic       scroll_en = 1'b0, clear = 1'b0;
  logic       gnt_a, gnt_b;
  logic [2:0] count;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;

  int n_cmp = 0;
  int n_bad = 0;

  hex_entry_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_a     (req_a),
    .digit_a   (digit_a),
    .req_b     (req_b),
    .digit_b   (digit_b),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .scroll_en (scroll_en),
    .clear     (clear),
    .count     (count),
    .hex0      (hex0),
    .hex1      (hex1),
    .hex2      (hex2),
    .hex3      (hex3),
    .hex4      (hex4),
    .hex5      (hex5)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Displayed digits as integers, -1 meaning blank; index 0 is the rightmost.
  int digs[6] = '{-1, -1, -1, -1, -1, -1};
  int mode    = M_IDLE;
  int scyc    = 0;
  bit last_a  = 1'b0;
  bit eg_a    = 1'b0;
  bit eg_b    = 1'b0;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000; 10: return 7'b0001000; 11: return 7'b0000011;
      12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110;
      15: return 7'b0001110;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [41:0] model_hex();
    logic [41:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r[i*7 +: 7] = (digs[i] < 0) ? 7'h7F : seg_of(digs[i]);
    return r;
  endfunction

  function automatic int model_count();
    int n;
    n = 0;
    for (int i = 0; i < 6; i++) if (digs[i] >= 0) n++;
    return n;
  endfunction

  task automatic mreset();
    for (int i = 0; i < 6; i++) digs[i] = -1;
    mode = M_IDLE; scyc = 0; last_a = 1'b0; eg_a = 1'b0; eg_b = 1'b0;
  endtask

  task automatic mblank();
    for (int i = 0; i < 6; i++) digs[i] = -1;
  endtask

  task automatic mstep();
    bit ta;
    int nd[6];
    eg_a = 1'b0;
    eg_b = 1'b0;
    case (mode)
      M_GRANTED: mode = M_IDLE;
      M_IDLE: begin
        if (clear) mblank();
        else if (scroll_en) begin
          mode = M_SCROLL;
          scyc = 0;
        end else if (req_a || req_b) begin
          ta = req_a && !(req_b && last_a);
          for (int i = 5; i > 0; i--) digs[i] = digs[i-1];
          digs[0] = ta ? int'(digit_a) : int'(digit_b);
          eg_a = ta;
          eg_b = !ta;
          last_a = ta;
          mode = M_GRANTED;
        end
      end
      default: begin
        if (clear) mblank();
        if (!scroll_en) mode = M_IDLE;
        else begin
          scyc++;
          if ((scyc % TICK_DIV) == 0 && !clear) begin
            for (int i = 0; i < 6; i++) nd[(i + 1) % 6] = digs[i];
            digs = nd;
          end
        end
      end
    endcase
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) mreset();
    else mstep();
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    chk("model_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(model_hex()));
    chk("model_count", 64'(count), 64'(model_count()));
    chk("model_gnt_a", 64'(gnt_a), 64'(eg_a));
    chk("model_gnt_b", 64'(gnt_b), 64'(eg_b));
    chk("gnt_exclusive", 64'(gnt_a & gnt_b), 64'd0);
  end

  task automatic wait_gnt(input bit for_a, input string nm);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      seen = for_a ? gnt_a : gnt_b;
    end
    chk(nm, 64'(seen), 64'd1);
  endtask

  task automatic wait_any(output int who);
    who = 0;
    for (int k = 0; k < 12 && who == 0; k++) begin
      @(negedge clk);
      if (gnt_a) who = 1;
      else if (gnt_b) who = 2;
    end
  endtask

  task automatic enter_a(input logic [3:0] d);
    req_a = 1'b1;
    digit_a = d;
    wait_gnt(1'b1, "enter_gnt");
    #1 req_a = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_a = 1'b0; req_b = 1'b0; scroll_en = 1'b0; clear = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int who;
    int exp_seq[4];
    exp_seq = '{1, 2, 1, 2};

    repeat (2) @(negedge clk);
    #1 reset = 1'b0;

    // Reset state, then idle.
    @(negedge clk);
    chk("rst_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'({6{7'h7F}}));
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_gnts", 64'({gnt_a, gnt_b}), 64'd0);

    // Single requester A with digit 3, held for a second grant.
    #1 req_a = 1'b1; digit_a = 4'h3;
    @(negedge clk);
    chk("a_gnt_latency", 64'(gnt_a), 64'd1);
    chk("a_hex0_3", 64'(hex0), 64'(7'b0110000));
    chk("a_count_1", 64'(count), 64'd1);
    @(negedge clk);
    chk("a_gnt_gap", 64'(gnt_a), 64'd0);
    @(negedge clk);
    chk("a_gnt_again", 64'(gnt_a), 64'd1);
    #1 req_a = 1'b0;

    // Both requesting from reset: alternating grants starting with A.
    reset = 1'b1;
    req_a = 1'b1; digit_a = 4'h1;
    req_b = 1'b1; digit_b = 4'h2;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_any(who);
      chk("rr_order", 64'(who), 64'(exp_seq[k]));
    end
    #1 req_a = 1'b0; req_b = 1'b0;

    // Seven entries: oldest digit dropped.
    do_reset();
    for (int d = 1; d <= 7; d++) enter_a(4'(d));
    @(negedge clk);
    chk("full_count", 64'(count), 64'd6);
    chk("full_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}),
        64'({7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000}));

    // Scroll with a pending B request held off until scroll_en drops.
    do_reset();
    enter_a(4'h1);
    enter_a(4'h2);
    scroll_en = 1'b1; req_b = 1'b1; digit_b = 4'h9;
    repeat (6) @(negedge clk);
    chk("scroll1_hex", 64'({hex3, hex2, hex1, hex0}),
        64'({7'h7F, 7'b1111001, 7'b0100100, 7'h7F}));
    repeat (4) @(negedge clk);
    chk("scroll2_hex", 64'({hex3, hex2, hex1, hex0}),
        64'({7'b1111001, 7'b0100100, 7'h7F, 7'h7F}));
    chk("scroll_count", 64'(count), 64'd2);
    @(negedge clk);
    #1 scroll_en = 1'b0;
    wait_gnt(1'b0, "b_after_scroll");
    #1 req_b = 1'b0;
    @(negedge clk);

    // Clear together with a request: clear first, grant on the next IDLE edge.
    #1 clear = 1'b1; req_a = 1'b1; digit_a = 4'hA;
    @(negedge clk);
    chk("clr_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'({6{7'h7F}}));
    chk("clr_count", 64'(count), 64'd0);
    chk("clr_no_gnt", 64'(gnt_a), 64'd0);
    #1 clear = 1'b0;
    @(negedge clk);
    chk("clr_then_gnt", 64'(gnt_a), 64'd1);
    chk("clr_then_hex0", 64'(hex0), 64'(7'b0001000));
    #1 req_a = 1'b0;
    @(negedge clk);

    // Reset in the middle of a grant.
    #1 req_a = 1'b1; digit_a = 4'h5;
    wait_gnt(1'b1, "pre_reset_gnt");
    #1 reset = 1'b1;
    #1;
    chk("midrst_gnt", 64'(gnt_a), 64'd0);
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_hex0", 64'(hex0), 64'(7'h7F));
    req_a = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
